// File: rtl/elevator_car_ctrl_if.sv
// -----------------------------------------------------------------------------
// elevator_car_ctrl_if
// Signal bundle between the floor-request side and the car controller.
//
// Request/handshake semantics: `change` is a single-cycle valid strobe with no
// ready/backpressure. `req_floor` is meaningful only while change=1. The
// controller samples the pair on the rising clock edge. While `busy` is high a
// request is either parked in a one-deep pending slot (ELEV_PENDING_REQ_EN
// builds) or silently dropped (default build).
//
// Members:
//   change      request strobe          (master -> slave)
//   req_floor   requested floor 0..3    (master -> slave)
//   cur_floor   current car floor       (slave -> master)
//   moving_up   car travelling up       (slave -> master)
//   moving_down car travelling down     (slave -> master)
//   door_open   door open               (slave -> master)
//   busy        controller not idle     (slave -> master)
//   arrived     pulse on door-open entry (slave -> master)
//   state_dbg   raw FSM state for observation (slave -> master)
// -----------------------------------------------------------------------------
interface elevator_car_ctrl_if;
  logic       change;
  logic [1:0] req_floor;
  logic [1:0] cur_floor;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;
  logic       busy;
  logic       arrived;
  logic [1:0] state_dbg;

  modport master (
    output change, req_floor,
    input  cur_floor, moving_up, moving_down, door_open, busy, arrived, state_dbg
  );

  modport slave (
    input  change, req_floor,
    output cur_floor, moving_up, moving_down, door_open, busy, arrived, state_dbg
  );
endinterface

// File: rtl/elevator_car_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_car_ctrl
// Car-motion controller for a 4-floor elevator. Takes the change strobe and
// requested floor from the upstream change detector, moves the car one floor
// per FLOOR_TICKS cycles, then holds the door open for DOOR_TICKS cycles.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset (returns car to floor 0, idle)
//   bus  elevator_car_ctrl_if.slave: change/req_floor in; cur_floor,
//        moving_up, moving_down, door_open, busy, arrived, state_dbg out
//
// Build option:
//   ELEV_PENDING_REQ_EN - when defined, a one-deep pending register holds the
//   newest request seen while busy and dispatches it when the door closes.
//   When undefined, requests arriving while busy are discarded.
//
// All outputs are registered and reflect the state entered on the last edge.
// -----------------------------------------------------------------------------
module elevator_car_ctrl #(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 4,
  parameter int CNT_W       = 4
) (
  input logic                clk,
  input logic                rst,
  elevator_car_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] FLOOR_LAST = CNT_W'(FLOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST  = CNT_W'(DOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       cur_floor_q, cur_floor_d;
  logic [1:0]       target_q, target_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             moving_up_q, moving_up_d;
  logic             moving_down_q, moving_down_d;
  logic             door_open_q, door_open_d;
  logic             busy_q, busy_d;
  logic             arrived_q, arrived_d;

  // A dispatch is a request acted on as if the car were idle: either a fresh
  // request in IDLE or (pending builds) the request released at door close.
  logic             disp_valid;
  logic [1:0]       disp_floor;

`ifdef ELEV_PENDING_REQ_EN
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_floor_q, pend_floor_d;
`endif

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    target_d    = target_q;
    timer_d     = timer_q;
    arrived_d   = 1'b0;
    disp_valid  = 1'b0;
    disp_floor  = bus.req_floor;
`ifdef ELEV_PENDING_REQ_EN
    pend_valid_d = pend_valid_q;
    pend_floor_d = pend_floor_q;
    // Busy-time request parks here; a newer one overwrites the older.
    if (state_q != IDLE && bus.change) begin
      pend_valid_d = 1'b1;
      pend_floor_d = bus.req_floor;
    end
`endif

    case (state_q)
      IDLE: begin
        disp_valid = bus.change;
        disp_floor = bus.req_floor;
      end

      MOVE_UP: begin
        if (timer_q == FLOOR_LAST) begin
          timer_d = '0;
          // Saturate rather than wrap; target range keeps this from binding.
          if (cur_floor_q != 2'd3) cur_floor_d = cur_floor_q + 2'd1;
          if (cur_floor_d == target_q) begin
            state_d   = DOOR_OPEN;
            arrived_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end

      MOVE_DOWN: begin
        if (timer_q == FLOOR_LAST) begin
          timer_d = '0;
          if (cur_floor_q != 2'd0) cur_floor_d = cur_floor_q - 2'd1;
          if (cur_floor_d == target_q) begin
            state_d   = DOOR_OPEN;
            arrived_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end

      DOOR_OPEN: begin
        if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          state_d = IDLE;
`ifdef ELEV_PENDING_REQ_EN
          // A request on this very edge is the newest one and wins over the
          // parked request; either way the slot is emptied.
          if (bus.change || pend_valid_q) begin
            disp_valid   = 1'b1;
            disp_floor   = bus.change ? bus.req_floor : pend_floor_q;
            pend_valid_d = 1'b0;
          end
`endif
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (disp_valid) begin
      timer_d  = '0;
      target_d = disp_floor;
      if (disp_floor > cur_floor_q) begin
        state_d = MOVE_UP;
      end else if (disp_floor < cur_floor_q) begin
        state_d = MOVE_DOWN;
      end else begin
        state_d   = DOOR_OPEN;
        arrived_d = 1'b1;
      end
    end

    // Outputs are decoded from the next state so they line up with it.
    moving_up_d   = (state_d == MOVE_UP);
    moving_down_d = (state_d == MOVE_DOWN);
    door_open_d   = (state_d == DOOR_OPEN);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_floor_q   <= 2'd0;
      target_q      <= 2'd0;
      timer_q       <= '0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      door_open_q   <= 1'b0;
      busy_q        <= 1'b0;
      arrived_q     <= 1'b0;
`ifdef ELEV_PENDING_REQ_EN
      pend_valid_q  <= 1'b0;
      pend_floor_q  <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      cur_floor_q   <= cur_floor_d;
      target_q      <= target_d;
      timer_q       <= timer_d;
      moving_up_q   <= moving_up_d;
      moving_down_q <= moving_down_d;
      door_open_q   <= door_open_d;
      busy_q        <= busy_d;
      arrived_q     <= arrived_d;
`ifdef ELEV_PENDING_REQ_EN
      pend_valid_q  <= pend_valid_d;
      pend_floor_q  <= pend_floor_d;
`endif
    end
  end

  assign bus.cur_floor   = cur_floor_q;
  assign bus.moving_up   = moving_up_q;
  assign bus.moving_down = moving_down_q;
  assign bus.door_open   = door_open_q;
  assign bus.busy        = busy_q;
  assign bus.arrived     = arrived_q;
  assign bus.state_dbg   = state_q;

  // Car must never be asked to step past the top or bottom floor.
  a_no_wrap_up: assert property (@(posedge clk) disable iff (rst)
    (state_q == MOVE_UP && timer_q == FLOOR_LAST) |-> (cur_floor_q != 2'd3));
  a_no_wrap_down: assert property (@(posedge clk) disable iff (rst)
    (state_q == MOVE_DOWN && timer_q == FLOOR_LAST) |-> (cur_floor_q != 2'd0));
  a_motion_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0({moving_up_q, moving_down_q, door_open_q}));
  a_arrived_in_door: assert property (@(posedge clk) disable iff (rst)
    arrived_q |-> door_open_q);

endmodule
